// File: rtl/ws2812_frame_tx.sv
// WS2812-class single-wire NRZ transmitter: streams NUM_PIXELS pixel words per frame,
// MSB first, with a one-entry hold buffer for gapless pixels and underrun abort.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line low, waiting for start
// ST_FETCH | waiting for the first pixel of the frame
// ST_HIGH  | high part of the current bit
// ST_LOW   | low part of the current bit; the next bit or pixel is chosen on its final cycle
// ST_LATCH | line held low for the latch period, then frame_done
module ws2812_frame_tx #(
    parameter int PIXEL_BITS = 24,
    parameter int NUM_PIXELS = 64,
    parameter int T0H_CYC    = 16,
    parameter int T0L_CYC    = 34,
    parameter int T1H_CYC    = 32,
    parameter int T1L_CYC    = 18,
    parameter int LATCH_CYC  = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [PIXEL_BITS-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  dout,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int CNT_W   = $clog2(NUM_PIXELS + 1);
    localparam int BIT_W   = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
    localparam int MAX_0   = (T0H_CYC > T0L_CYC) ? T0H_CYC : T0L_CYC;
    localparam int MAX_1   = (T1H_CYC > T1L_CYC) ? T1H_CYC : T1L_CYC;
    localparam int MAX_01  = (MAX_0 > MAX_1) ? MAX_0 : MAX_1;
    localparam int MAX_CYC = (MAX_01 > LATCH_CYC) ? MAX_01 : LATCH_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] T0H_LD   = TMR_W'(T0H_CYC - 1);
    localparam logic [TMR_W-1:0] T0L_LD   = TMR_W'(T0L_CYC - 1);
    localparam logic [TMR_W-1:0] T1H_LD   = TMR_W'(T1H_CYC - 1);
    localparam logic [TMR_W-1:0] T1L_LD   = TMR_W'(T1L_CYC - 1);
    localparam logic [TMR_W-1:0] LATCH_LD = TMR_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] NUM_PIX  = CNT_W'(NUM_PIXELS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PIXEL_BITS-1:0]   shift;
    logic [PIXEL_BITS-1:0]   shift_next;
    logic [PIXEL_BITS-1:0]   hold;
    logic                    hold_full;
    logic [CNT_W-1:0]        req_cnt;
    logic [CNT_W-1:0]        sent_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [TMR_W-1:0]        timer;
    logic                    timer_zero;
    logic                    xfer;
    logic                    load_hold;
    logic                    load_pix;
    logic                    load;
    logic                    shift_bit;
    logic                    underrun_evt;

    assign timer_zero = (timer == '0);
    assign xfer       = pix_valid & pix_ready;
    assign load       = load_hold | load_pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_hold    = 1'b0;
        load_pix     = 1'b0;
        shift_bit    = 1'b0;
        underrun_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (hold_full) begin
                    load_hold  = 1'b1;
                    state_next = ST_HIGH;
                end else if (xfer) begin
                    load_pix   = 1'b1;
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (timer_zero) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (timer_zero) begin
                    if (bit_cnt != LAST_BIT) begin
                        shift_bit  = 1'b1;
                        state_next = ST_HIGH;
                    end else if (sent_cnt == NUM_PIX) begin
                        state_next = ST_LATCH;
                    end else if (hold_full) begin
                        load_hold  = 1'b1;
                        state_next = ST_HIGH;
                    end else if (xfer) begin
                        load_pix   = 1'b1;
                        state_next = ST_HIGH;
                    end else begin
                        underrun_evt = 1'b1;
                        state_next   = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (timer_zero) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        pix_ready = busy && (state != ST_LATCH) && !hold_full && (req_cnt < NUM_PIX);
        underrun  = underrun_evt;
    end

    always_comb begin
        shift_next = shift << 1;
        if (load_hold) begin
            shift_next = hold;
        end else if (load_pix) begin
            shift_next = pix_data;
        end
    end

    // The timer is loaded with (duration - 1) on entry to a phase and the phase ends at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            req_cnt    <= '0;
            sent_cnt   <= '0;
            bit_cnt    <= '0;
            timer      <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                req_cnt   <= '0;
                sent_cnt  <= '0;
                bit_cnt   <= '0;
                hold_full <= 1'b0;
            end else begin
                if (xfer) req_cnt <= req_cnt + CNT_W'(1);
                if (load) begin
                    shift    <= shift_next;
                    bit_cnt  <= '0;
                    sent_cnt <= sent_cnt + CNT_W'(1);
                end else if (shift_bit) begin
                    shift   <= shift_next;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                if (xfer && !load_pix) begin
                    hold      <= pix_data;
                    hold_full <= 1'b1;
                end else if (load_hold) begin
                    hold_full <= 1'b0;
                end
            end

            if (state_next == ST_HIGH && state != ST_HIGH) begin
                timer <= shift_next[PIXEL_BITS-1] ? T1H_LD : T0H_LD;
            end else if (state_next == ST_LOW && state == ST_HIGH) begin
                timer <= shift[PIXEL_BITS-1] ? T1L_LD : T0L_LD;
            end else if (state_next == ST_LATCH && state != ST_LATCH) begin
                timer <= LATCH_LD;
            end else if (!timer_zero) begin
                timer <= timer - TMR_W'(1);
            end

            dout       <= (state_next == ST_HIGH);
            frame_done <= (state == ST_LATCH) && (state_next == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: per-frame timeline model built from pixel offer times and
// bit timings, compared cycle by cycle against dout/busy/pix_ready/underrun/frame_done.
module tb_ws2812_frame_tx;

    localparam int PB   = 8;
    localparam int NP   = 2;
    localparam int T0H  = 2;
    localparam int T0L  = 3;
    localparam int T1H  = 3;
    localparam int T1L  = 2;
    localparam int LAT  = 10;
    localparam int MAXC = 256;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pix_valid;
    logic [PB-1:0] pix_data;
    logic          pix_ready;
    logic          dout;
    logic          busy;
    logic          frame_done;
    logic          underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PB-1:0] px[NP];
    int            av[NP];
    int            t_st[NP];
    int            e_end[NP];
    int            rdy[NP];
    int            acc[NP];
    int            n_acc;
    bit            und;
    int            fend;
    bit            e_dout[MAXC];
    bit            e_busy[MAXC];
    bit            e_rdy[MAXC];
    bit            e_und[MAXC];

    always #5 clk = ~clk;

    ws2812_frame_tx #(
        .PIXEL_BITS(PB), .NUM_PIXELS(NP),
        .T0H_CYC(T0H), .T0L_CYC(T0L), .T1H_CYC(T1H), .T1L_CYC(T1L),
        .LATCH_CYC(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .dout(dout), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-relative timeline: pixel i is offered from av[i] and held until taken.
    task automatic build_model();
        int c;
        und   = 1'b0;
        n_acc = NP;
        for (int i = 0; i < MAXC; i++) begin
            e_dout[i] = 1'b0; e_busy[i] = 1'b0; e_rdy[i] = 1'b0; e_und[i] = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            rdy[i] = (i == 0) ? 1 : t_st[i-1];
            acc[i] = (av[i] > rdy[i]) ? av[i] : rdy[i];
            if (i > 0 && acc[i] > e_end[i-1]) begin
                und   = 1'b1;
                n_acc = i;
                break;
            end
            t_st[i] = (i == 0) ? acc[i] + 1 : e_end[i-1] + 1;
            c = t_st[i];
            for (int b = PB - 1; b >= 0; b--) begin
                int h;
                int l;
                h = px[i][b] ? T1H : T0H;
                l = px[i][b] ? T1L : T0L;
                for (int k = 0; k < h; k++) e_dout[c + k] = 1'b1;
                c += h + l;
            end
            e_end[i] = c - 1;
        end
        fend = e_end[n_acc-1] + LAT;
        for (int i = 1; i <= fend; i++) e_busy[i] = 1'b1;
        for (int i = 0; i < n_acc; i++)
            for (int k = rdy[i]; k <= acc[i]; k++) e_rdy[k] = 1'b1;
        if (und) begin
            for (int k = rdy[n_acc]; k <= e_end[n_acc-1]; k++) e_rdy[k] = 1'b1;
            e_und[e_end[n_acc-1]] = 1'b1;
        end
    endtask

    task automatic run_frame(input bit chained, input int mid_start, input bit do_abort);
        int idx;
        int nx;
        int last;
        int abort_at;
        int a_cur;
        idx = 0;
        nx  = 0;
        build_model();
        abort_at = do_abort ? t_st[0] + 1 : -1;
        last     = do_abort ? abort_at + 1 : fend;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (c == mid_start);
            reset     = (c == abort_at);
            a_cur     = (idx < NP) ? av[idx] : NEVER;
            pix_valid = (idx < NP) && (c >= a_cur) && (c <= fend);
            pix_data  = pix_valid ? px[idx] : PB'($urandom);
            @(negedge clk);
            if (do_abort && c == abort_at + 1) begin
                chk($sformatf("rst_dout@%0d", c), dout, 0);
                chk($sformatf("rst_busy@%0d", c), busy, 0);
                chk($sformatf("rst_ready@%0d", c), pix_ready, 0);
                chk($sformatf("rst_done@%0d", c), frame_done, 0);
                chk($sformatf("rst_und@%0d", c), underrun, 0);
            end else begin
                chk($sformatf("dout@%0d", c), dout, e_dout[c]);
                chk($sformatf("busy@%0d", c), busy, e_busy[c]);
                chk($sformatf("ready@%0d", c), pix_ready, e_rdy[c]);
                chk($sformatf("underrun@%0d", c), underrun, e_und[c]);
                chk($sformatf("done@%0d", c), frame_done, (c == 0) && chained);
            end
            if (pix_valid && pix_ready) begin
                idx++;
                nx++;
            end
        end
        if (!do_abort) chk("xfer_count", nx, n_acc);
        start     = 1'b0;
        reset     = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit done_first);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            pix_valid = 1'b0;
            @(negedge clk);
            chk("idle_dout", dout, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ready", pix_ready, 0);
            chk("idle_done", frame_done, (i == 0) && done_first);
        end
    endtask

    task automatic set_frame(input logic [PB-1:0] d0, input logic [PB-1:0] d1,
                             input int a0, input int a1);
        px[0] = d0; px[1] = d1;
        av[0] = a0; av[1] = a1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_dout", dout, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", pix_ready, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_und", underrun, 0);

        set_frame(8'hA5, 8'h0F, 0, 0);
        run_frame(1'b0, -1, 1'b0);
        idle(3, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 4, 4);
        run_frame(1'b0, -1, 1'b0);
        idle(2, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 0, NEVER);
        run_frame(1'b0, -1, 1'b0);
        idle(2, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 2, 10);
        run_frame(1'b0, -1, 1'b0);
        idle(2, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 0, 41);
        run_frame(1'b0, -1, 1'b0);
        idle(2, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 0, 42);
        run_frame(1'b0, -1, 1'b0);
        idle(2, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 0, 0);
        run_frame(1'b0, 30, 1'b0);
        set_frame(PB'($urandom), PB'($urandom), 1, 3);
        run_frame(1'b1, 85, 1'b0);
        idle(2, 1'b1);

        set_frame(PB'($urandom), PB'($urandom), 0, 0);
        run_frame(1'b0, -1, 1'b1);
        idle(2, 1'b0);
        set_frame(PB'($urandom), PB'($urandom), 0, 0);
        run_frame(1'b0, -1, 1'b0);
        idle(2, 1'b1);

        for (int r = 0; r < 10; r++) begin
            set_frame(PB'($urandom), PB'($urandom), $urandom_range(0, 6), $urandom_range(0, 50));
            if (r % 3 == 2) begin
                run_frame(1'b0, -1, 1'b0);
                set_frame(PB'($urandom), PB'($urandom), $urandom_range(0, 6), $urandom_range(0, 50));
                run_frame(1'b1, -1, 1'b0);
            end else begin
                run_frame(1'b0, -1, 1'b0);
            end
            idle(1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
